// File: rtl/bram_rd_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : bram_rd_arbiter
// Description : Round-robin arbiter sharing one trig/done (4-phase) BRAM read
//               port among NUM_REQ requesters. One outstanding read at a time.
//               Optional macro BRAM_ARB_TIMEOUT_EN adds an ISSUE-state
//               watchdog that aborts a read after TIMEOUT_CYC cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module bram_rd_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int ADDR_W      = 13,
    parameter int DATA_W      = 32,
    parameter int TIMEOUT_CYC = 1023
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic [NUM_REQ-1:0]          i_req_trig,
    input  logic [NUM_REQ*ADDR_W-1:0]   i_req_addr,
    output logic [NUM_REQ-1:0]          o_req_done,
    output logic [DATA_W-1:0]           o_req_data,
    output logic [$clog2(NUM_REQ)-1:0]  o_grant_id,
    output logic                        o_busy,
    output logic                        o_timeout,
    output logic [ADDR_W-1:0]           o_bram_addr,
    output logic                        o_bram_trig,
    input  logic [DATA_W-1:0]           i_bram_data,
    input  logic                        i_bram_done
);

    localparam int C_ID_W = $clog2(NUM_REQ);

    typedef enum logic [1:0] {
        C_ST_IDLE  = 2'd0,
        C_ST_ISSUE = 2'd1,
        C_ST_RESP  = 2'd2
    } state_t;

    // Elaboration-time sanity check of the configuration
    if ((NUM_REQ < 2) || (NUM_REQ > 8) || (TIMEOUT_CYC < 1)) begin : g_param_chk
        $error("bram_rd_arbiter: NUM_REQ must be 2..8 and TIMEOUT_CYC >= 1");
    end

    state_t                r_state_q, w_state_d;
    logic [C_ID_W-1:0]     r_ptr_q,   w_ptr_d;
    logic [C_ID_W-1:0]     r_gid_q,   w_gid_d;
    logic [ADDR_W-1:0]     r_addr_q,  w_addr_d;
    logic                  r_trig_q,  w_trig_d;
    logic [DATA_W-1:0]     r_data_q,  w_data_d;
    logic [NUM_REQ-1:0]    r_done_q,  w_done_d;
    logic                  w_tout_d;

    logic [ADDR_W-1:0]     w_addr_arr [NUM_REQ];
    logic [C_ID_W-1:0]     w_gnt;
    logic                  w_any;

    // Unpack the flat address bus into one word per requester
    for (genvar k = 0; k < NUM_REQ; k++) begin : g_addr
        assign w_addr_arr[k] = i_req_addr[k*ADDR_W +: ADDR_W];
    end

    // Round-robin search: first requesting index after the pointer, wrapping
    always_comb begin
        int idx;
        w_any = |i_req_trig;
        w_gnt = '0;
        idx   = 0;
        // Walk from lowest priority to highest so the highest priority wins last
        for (int i = NUM_REQ; i >= 1; i--) begin
            idx = (int'(r_ptr_q) + i) % NUM_REQ;
            if (i_req_trig[idx]) begin
                w_gnt = C_ID_W'(idx);
            end
        end
    end

`ifdef BRAM_ARB_TIMEOUT_EN
    localparam int C_CNT_W = ($clog2(TIMEOUT_CYC + 1) > 10) ? $clog2(TIMEOUT_CYC + 1) : 10;
    logic [C_CNT_W-1:0] r_cnt_q, w_cnt_d;
    logic               r_tout_q;
`endif

    // Next-state and registered-output logic for the IDLE/ISSUE/RESP handshake
    always_comb begin
        w_state_d = r_state_q;
        w_ptr_d   = r_ptr_q;
        w_gid_d   = r_gid_q;
        w_addr_d  = r_addr_q;
        w_trig_d  = r_trig_q;
        w_data_d  = r_data_q;
        w_done_d  = r_done_q;
        w_tout_d  = 1'b0;
`ifdef BRAM_ARB_TIMEOUT_EN
        w_cnt_d   = r_cnt_q;
`endif
        case (r_state_q)
            C_ST_IDLE: begin
                if (w_any) begin
                    w_gid_d   = w_gnt;
                    w_addr_d  = w_addr_arr[w_gnt];
                    w_trig_d  = 1'b1;
                    w_state_d = C_ST_ISSUE;
`ifdef BRAM_ARB_TIMEOUT_EN
                    w_cnt_d   = '0;
`endif
                end
            end
            C_ST_ISSUE: begin
                if (i_bram_done) begin
                    w_data_d           = i_bram_data;
                    w_trig_d           = 1'b0;
                    w_done_d           = '0;
                    w_done_d[r_gid_q]  = 1'b1;
                    w_state_d          = C_ST_RESP;
                end
`ifdef BRAM_ARB_TIMEOUT_EN
                else begin
                    w_cnt_d = r_cnt_q + 1'b1;
                    // Abort on the TIMEOUT_CYC-th ISSUE cycle without a done
                    if (w_cnt_d == C_CNT_W'(TIMEOUT_CYC)) begin
                        w_data_d          = '0;
                        w_trig_d          = 1'b0;
                        w_done_d          = '0;
                        w_done_d[r_gid_q] = 1'b1;
                        w_tout_d          = 1'b1;
                        w_state_d         = C_ST_RESP;
                    end
                end
`endif
            end
            C_ST_RESP: begin
                // Wait for both the requester and the BRAM side to release
                if (!i_req_trig[r_gid_q] && !i_bram_done) begin
                    w_done_d  = '0;
                    w_ptr_d   = r_gid_q;
                    w_state_d = C_ST_IDLE;
                end
            end
            default: begin
                w_state_d = C_ST_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state_q <= C_ST_IDLE;
            r_ptr_q   <= C_ID_W'(NUM_REQ - 1);
            r_gid_q   <= '0;
            r_addr_q  <= '0;
            r_trig_q  <= 1'b0;
            r_data_q  <= '0;
            r_done_q  <= '0;
        end else begin
            r_state_q <= w_state_d;
            r_ptr_q   <= w_ptr_d;
            r_gid_q   <= w_gid_d;
            r_addr_q  <= w_addr_d;
            r_trig_q  <= w_trig_d;
            r_data_q  <= w_data_d;
            r_done_q  <= w_done_d;
        end
    end

`ifdef BRAM_ARB_TIMEOUT_EN
    // Watchdog counter and one-cycle timeout pulse
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt_q  <= '0;
            r_tout_q <= 1'b0;
        end else begin
            r_cnt_q  <= w_cnt_d;
            r_tout_q <= w_tout_d;
        end
    end
    assign o_timeout = r_tout_q;
`else
    assign o_timeout = w_tout_d & 1'b0;
`endif

    assign o_req_done  = r_done_q;
    assign o_req_data  = r_data_q;
    assign o_grant_id  = r_gid_q;
    assign o_busy      = (r_state_q != C_ST_IDLE);
    assign o_bram_addr = r_addr_q;
    assign o_bram_trig = r_trig_q;

endmodule
`default_nettype wire
